// File: rtl/fetch_unit_pkg.sv
// Shared constants, entry type and counter sizing for the instruction-fetch stage.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Width able to hold every value 0..depth inclusive.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return unsigned'($clog2(depth + 1));
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch stage and memory.
interface fetch_unit_if;

  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );

endinterface

// File: rtl/fetch_fifo.sv
// Response buffer of {pc, instr} entries; flush wins over push and pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CW    = cnt_w(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_flush,
  input  fetch_entry_t i_data,
  output logic [CW-1:0] o_count,
  output fetch_entry_t o_head
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t   r_mem [DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [CW-1:0]  r_count;

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
  end

  always_comb begin
    o_count = r_count;
    o_head  = r_mem[r_rd_ptr];
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: credit-limited pipelined imem requests, response FIFO
// with empty-FIFO bypass, redirect with wrong-path response dropping, IF/ID register.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned DEPTH    = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid_PC,
  input  logic                valid_F,
  input  logic                flash_D,
  input  logic                PCSrc_E,
  input  logic [31:0]         PCTarget_E,
  fetch_unit_if.master        imem,
  output logic [31:0]         Instr_D,
  output logic [31:0]         PC_D,
  output logic [31:0]         PCPlus4_D,
  output logic                inst_valid_D
);

  localparam int unsigned CW      = cnt_w(DEPTH);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  logic [31:0]   r_pc;
  logic [31:0]   r_rsp_pc;
  logic [CW-1:0] r_inflight;
  logic [CW-1:0] r_drop_cnt;
  logic [31:0]   r_instr_d;
  logic [31:0]   r_pc_d;
  logic [31:0]   r_pc4_d;
  logic          r_valid_d;

  logic [CW-1:0] w_fifo_count;
  fetch_entry_t  w_head;
  fetch_entry_t  w_push_data;
  logic [CW:0]   w_credit_used;
  logic [31:0]   w_target;
  logic          w_req_valid;
  logic          w_req_fire;
  logic          w_rsp_kept;
  logic          w_fifo_empty;
  logic          w_load_head;
  logic          w_bypass;
  logic          w_push;

  always_comb begin
    w_credit_used = {1'b0, r_inflight} + {1'b0, w_fifo_count};
    w_target      = PCTarget_E & ~32'h0000_0003;
    // Reset gates the strobe so it is low the moment rst falls.
    w_req_valid   = rst & valid_PC & ~PCSrc_E & (w_credit_used < DEPTH_W);
    w_req_fire    = w_req_valid & imem.imem_req_ready;
    w_rsp_kept    = imem.imem_rsp_valid & ~PCSrc_E & (r_drop_cnt == '0);
    w_fifo_empty  = (w_fifo_count == '0);
    w_load_head   = valid_F & ~flash_D & ~w_fifo_empty;
    w_bypass      = valid_F & ~flash_D & w_fifo_empty & w_rsp_kept;
    w_push        = w_rsp_kept & ~w_bypass;
    w_push_data.pc    = r_rsp_pc;
    w_push_data.instr = imem.imem_rsp_data;
  end

  assign imem.imem_req_valid = w_req_valid;
  assign imem.imem_req_addr  = r_pc;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_load_head),
    .i_flush (PCSrc_E),
    .i_data  (w_push_data),
    .o_count (w_fifo_count),
    .o_head  (w_head)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc       <= RESET_PC;
      r_rsp_pc   <= RESET_PC;
      r_inflight <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_inflight <= r_inflight + CW'(w_req_fire) - CW'(imem.imem_rsp_valid);
      if (PCSrc_E) begin
        r_pc       <= w_target;
        r_rsp_pc   <= w_target;
        // Everything still outstanding after this cycle belongs to the old path.
        r_drop_cnt <= r_inflight - CW'(imem.imem_rsp_valid);
      end else begin
        if (w_req_fire) r_pc <= r_pc + 32'd4;
        if (w_rsp_kept) r_rsp_pc <= r_rsp_pc + 32'd4;
        if (imem.imem_rsp_valid && (r_drop_cnt != '0)) r_drop_cnt <= r_drop_cnt - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_instr_d <= NOP_INSTR;
      r_pc_d    <= 32'h0000_0000;
      r_pc4_d   <= 32'h0000_0004;
      r_valid_d <= 1'b0;
    end else if (flash_D) begin
      r_instr_d <= NOP_INSTR;
      r_valid_d <= 1'b0;
    end else if (valid_F) begin
      if (w_load_head) begin
        r_instr_d <= w_head.instr;
        r_pc_d    <= w_head.pc;
        r_pc4_d   <= w_head.pc + 32'd4;
        r_valid_d <= 1'b1;
      end else if (w_bypass) begin
        r_instr_d <= imem.imem_rsp_data;
        r_pc_d    <= r_rsp_pc;
        r_pc4_d   <= r_rsp_pc + 32'd4;
        r_valid_d <= 1'b1;
      end else begin
        r_instr_d <= NOP_INSTR;
        r_valid_d <= 1'b0;
      end
    end
  end

  always_comb begin
    Instr_D      = r_instr_d;
    PC_D         = r_pc_d;
    PCPlus4_D    = r_pc4_d;
    inst_valid_D = r_valid_d;
  end

  a_no_underflow: assert property (@(posedge clk) disable iff (!rst)
    imem.imem_rsp_valid |-> (r_inflight != '0));
  a_fifo_bound: assert property (@(posedge clk) disable iff (!rst)
    w_fifo_count <= CW'(DEPTH));
  a_inflight_bound: assert property (@(posedge clk) disable iff (!rst)
    r_inflight <= CW'(DEPTH));

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against a queue-based model of the fetch rules.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int unsigned DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_PC, valid_F, flash_D, PCSrc_E;
  logic [31:0] PCTarget_E;
  logic [31:0] Instr_D, PC_D, PCPlus4_D;
  logic        inst_valid_D;

  fetch_unit_if imem_bus ();

  fetch_unit #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .valid_PC     (valid_PC),
    .valid_F      (valid_F),
    .flash_D      (flash_D),
    .PCSrc_E      (PCSrc_E),
    .PCTarget_E   (PCTarget_E),
    .imem         (imem_bus),
    .Instr_D      (Instr_D),
    .PC_D         (PC_D),
    .PCPlus4_D    (PCPlus4_D),
    .inst_valid_D (inst_valid_D)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Model: outstanding requests carry their own address and a live flag;
  // a redirect simply marks them all dead.
  typedef struct { logic [31:0] addr; bit live; } osd_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
  typedef struct { logic [31:0] addr; int due; } mreq_t;

  osd_t  osq[$];
  ent_t  bufq[$];
  mreq_t memq[$];

  logic [31:0] m_pc, m_instr, m_pcd, m_pc4;
  bit          m_valid;
  bit          exp_req_valid;
  logic [31:0] exp_req_addr;
  bit          chk_en = 1'b0;
  int          cyc = 0;

  bit          d_rst, d_vpc, d_vf, d_flash, d_pcsrc, d_ready;
  logic [31:0] d_tgt;
  int          mem_extra_min = 0;
  int          mem_extra_max = 0;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0033;
  endfunction

  task automatic model_reset();
    m_pc = RST_PC;
    osq.delete();
    bufq.delete();
    memq.delete();
    m_instr = NOP_INSTR;
    m_pcd = 32'h0;
    m_pc4 = 32'h4;
    m_valid = 1'b0;
    exp_req_valid = 1'b0;
    exp_req_addr = RST_PC;
  endtask

  task automatic model_advance(input bit fire, input bit rv, input logic [31:0] rdata,
                               input bit vf, input bit flash, input bit pcsrc,
                               input logic [31:0] tgt);
    bit kept = 1'b0;
    logic [31:0] kpc = '0;
    ent_t e;
    if (rv && osq.size() > 0) begin
      osd_t o = osq.pop_front();
      kept = o.live && !pcsrc;
      kpc = o.addr;
    end
    if (pcsrc) foreach (osq[i]) osq[i].live = 1'b0;
    if (flash) begin
      m_valid = 1'b0;
      m_instr = NOP_INSTR;
    end else if (vf) begin
      if (bufq.size() > 0) begin
        e = bufq.pop_front();
        m_instr = e.instr; m_pcd = e.pc; m_pc4 = e.pc + 32'd4; m_valid = 1'b1;
      end else if (kept) begin
        m_instr = rdata; m_pcd = kpc; m_pc4 = kpc + 32'd4; m_valid = 1'b1;
        kept = 1'b0;
      end else begin
        m_instr = NOP_INSTR; m_valid = 1'b0;
      end
    end
    if (kept) bufq.push_back('{kpc, rdata});
    if (fire) begin
      osq.push_back('{m_pc, 1'b1});
      m_pc = m_pc + 32'd4;
    end
    if (pcsrc) begin
      bufq.delete();
      m_pc = {tgt[31:2], 2'b00};
    end
  endtask

  // Drives one cycle's inputs, lets the edge pass, then advances the model.
  task automatic cycle();
    bit rv = 1'b0;
    logic [31:0] rd = $urandom();
    bit fire;
    logic [31:0] faddr;
    rst = d_rst; valid_PC = d_vpc; valid_F = d_vf; flash_D = d_flash;
    PCSrc_E = d_pcsrc; PCTarget_E = d_tgt;
    imem_bus.imem_req_ready = d_ready;
    if (d_rst && memq.size() > 0 && memq[0].due <= cyc) begin
      rv = 1'b1;
      rd = memfn(memq[0].addr);
      void'(memq.pop_front());
    end
    imem_bus.imem_rsp_valid = rv;
    imem_bus.imem_rsp_data  = rd;
    exp_req_valid = d_rst && d_vpc && !d_pcsrc && (osq.size() + bufq.size() < DEPTH);
    exp_req_addr  = m_pc;
    fire  = exp_req_valid && d_ready;
    faddr = m_pc;
    @(posedge clk);
    #1;
    cyc++;
    if (!d_rst) model_reset();
    else begin
      if (fire) memq.push_back('{faddr, cyc + int'($urandom_range(mem_extra_max, mem_extra_min))});
      model_advance(fire, rv, rd, d_vf, d_flash, d_pcsrc, d_tgt);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("inst_valid_D", 32'(inst_valid_D), 32'(m_valid));
      chk("Instr_D", Instr_D, m_instr);
      chk("PC_D", PC_D, m_pcd);
      chk("PCPlus4_D", PCPlus4_D, m_pc4);
      chk("imem_req_valid", 32'(imem_bus.imem_req_valid), 32'(exp_req_valid));
      if (exp_req_valid) chk("imem_req_addr", imem_bus.imem_req_addr, exp_req_addr);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  int exp_a_pc[11] = '{0, 0, 4, 8, 8, 8, 8, 12, 16, 20, 24};
  int n;

  initial begin
    d_rst = 0; d_vpc = 1; d_vf = 1; d_flash = 0; d_pcsrc = 0; d_ready = 1; d_tgt = '0;
    rst = 0; valid_PC = 0; valid_F = 0; flash_D = 0; PCSrc_E = 0; PCTarget_E = '0;
    imem_bus.imem_req_ready = 0; imem_bus.imem_rsp_valid = 0; imem_bus.imem_rsp_data = '0;
    model_reset();
    repeat (2) cycle();
    chk("rst_Instr_D", Instr_D, 32'h0000_0013);
    chk("rst_PC_D", PC_D, 32'h0);
    chk("rst_PCPlus4_D", PCPlus4_D, 32'h4);
    chk("rst_inst_valid_D", 32'(inst_valid_D), 32'h0);
    chk("rst_req_valid", 32'(imem_bus.imem_req_valid), 32'h0);
    chk_en = 1'b1;

    // 1-cycle memory, back-to-back fetch, then a 3-cycle decode stall.
    d_rst = 1;
    for (int i = 0; i < 11; i++) begin
      d_vf = !(i >= 4 && i <= 6);
      cycle();
      chk("A_inst_valid", 32'(inst_valid_D), (i == 0) ? 32'h0 : 32'h1);
      if (i > 0) begin
        chk("A_PC_D", PC_D, 32'(exp_a_pc[i]));
        chk("A_PCPlus4_D", PCPlus4_D, 32'(exp_a_pc[i] + 4));
        chk("A_Instr_D", Instr_D, memfn(32'(exp_a_pc[i])));
      end
    end

    // Slow memory so several requests are in flight, then redirect.
    mem_extra_min = 2; mem_extra_max = 2;
    repeat (4) cycle();
    d_pcsrc = 1; d_flash = 1; d_tgt = 32'h0000_0103;
    cycle();
    chk("B_flash_valid", 32'(inst_valid_D), 32'h0);
    d_pcsrc = 0; d_flash = 0;
    n = 0;
    while (!inst_valid_D && n < 20) begin cycle(); n++; end
    chk("B_first_valid", 32'(inst_valid_D), 32'h1);
    chk("B_target_PC_D", PC_D, 32'h0000_0100);
    chk("B_target_PCPlus4", PCPlus4_D, 32'h0000_0104);
    chk("B_target_Instr", Instr_D, memfn(32'h0000_0100));

    // Memory refuses requests: pipeline drains into bubbles.
    d_ready = 0;
    repeat (6) cycle();
    chk("C_bubble_valid", 32'(inst_valid_D), 32'h0);
    chk("C_bubble_instr", Instr_D, 32'h0000_0013);
    d_ready = 1; mem_extra_min = 0; mem_extra_max = 0;
    repeat (5) cycle();

    // Asynchronous reset in the middle of a cycle.
    #2;
    rst = 0; d_rst = 0;
    model_reset();
    #1;
    chk("D_async_Instr_D", Instr_D, 32'h0000_0013);
    chk("D_async_PC_D", PC_D, 32'h0);
    chk("D_async_PCPlus4", PCPlus4_D, 32'h4);
    chk("D_async_valid", 32'(inst_valid_D), 32'h0);
    chk("D_async_req_valid", 32'(imem_bus.imem_req_valid), 32'h0);
    cycle();
    d_rst = 1;
    n = 0;
    do begin cycle(); n++; end while (!inst_valid_D && n < 10);
    chk("D_restart_valid", 32'(inst_valid_D), 32'h1);
    chk("D_restart_PC_D", PC_D, RST_PC);

    // Randomized traffic including redirects near the top of the address space.
    mem_extra_min = 0; mem_extra_max = 2;
    for (int i = 0; i < 3000; i++) begin
      d_vpc   = ($urandom_range(9, 0) != 0);
      d_vf    = ($urandom_range(4, 0) != 0);
      d_pcsrc = ($urandom_range(19, 0) == 0);
      d_flash = d_pcsrc || ($urandom_range(24, 0) == 0);
      d_tgt   = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(15, 0)))
                                            : $urandom();
      d_ready = ($urandom_range(3, 0) != 0);
      cycle();
    end

    d_pcsrc = 0; d_flash = 0;
    repeat (2) cycle();
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage sitting directly upstream of the IF/ID register and the hazard/valid controller.
- Issues pipelined requests to instruction memory and buffers returned words in a small FIFO.
- Presents one instruction per cycle to decode under the controller's valid_PC, valid_F and flash_D, and redirects on PCSrc_E.
- Decouples memory latency from pipeline stalls; drops wrong-path responses after a redirect.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
DEPTH, 2, response FIFO entries = max requests in flight + buffered (power of 2, ≥2)

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-low
valid_PC  in  1  1 = new memory requests may issue; 0 = hold PC
valid_F  in  1  1 = IF/ID register may load; 0 = hold decode outputs
flash_D  in  1  squash the decode register (bubble)
PCSrc_E  in  1  taken branch/jump resolved in E: redirect
PCTarget_E  in  32  redirect address
imem_req_valid  out  1  request strobe
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  32  word address, bits[1:0]=0
imem_rsp_valid  in  1  response strobe, in request order, no backpressure
imem_rsp_data  in  32  instruction word
Instr_D  out  32  instruction to decode
PC_D  out  32  PC of Instr_D
PCPlus4_D  out  32  PC_D+4
inst_valid_D  out  1  Instr_D is real (0 = bubble)

Behaviour:
- Reset (rst=0, async): pc_q=RESET_PC, rsp_pc=RESET_PC, inflight=0, drop_cnt=0, FIFO empty; Instr_D=32'h0000_0013 (NOP), PC_D=0, PCPlus4_D=4, inst_valid_D=0, imem_req_valid=0. Release mid-transfer: all stale responses are the memory's responsibility; the block restarts clean.
- Credit: imem_req_valid = valid_PC & ~PCSrc_E & (inflight + fifo_count < DEPTH). imem_req_addr = pc_q. On handshake: pc_q += 4 (32-bit wrap), inflight++.
- Response: each imem_rsp_valid decrements inflight. If drop_cnt>0: discard, drop_cnt--. Else push {rsp_pc, data}; rsp_pc += 4.
- Redirect (PCSrc_E=1): pc_q = rsp_pc = {PCTarget_E[31:2],2'b00}; FIFO flushed; a response arriving this cycle is discarded; drop_cnt ← inflight − imem_rsp_valid (all still in flight become drops). No request issues this cycle. First target request issues next cycle at earliest.
- Decode register update, priority order:
  1. flash_D=1: inst_valid_D←0, Instr_D←NOP, PC_D/PCPlus4_D hold.
  2. valid_F=0: all hold; FIFO does not pop.
  3. FIFO non-empty: pop head into Instr_D/PC_D/PCPlus4_D, inst_valid_D←1.
  4. FIFO empty, kept response arriving: bypass it straight into the decode register, inst_valid_D←1; no push.
  5. Otherwise: bubble, inst_valid_D←0, Instr_D←NOP.
- Push and pop in the same cycle are legal at full. Credit guarantees a push never overflows: assert fifo_count ≤ DEPTH.
- Counter widths: $clog2(DEPTH+1). inflight never exceeds DEPTH. Underflow (response with inflight=0) is an assertion failure.
- Latency: request accepted in cycle N, response in N+1 → Instr_D valid at N+2 edge via bypass.

Decomposition:
- Package fetch_pkg: NOP_INSTR=32'h0000_0013, default RESET_PC, FIFO count width function.
- One sub-module fetch_fifo: synchronous DEPTH×64 FIFO with push, pop, flush, count, head; flush has priority over push.

Test Plan:
- Reset, 1-cycle memory, valid_PC=valid_F=1 → addresses 0,4,8,… issued back to back; inst_valid_D rises 2 cycles after first request; PC_D steps by 4 each cycle.
- Stall: valid_F=0 for 3 cycles with DEPTH=2 → at most 2 requests outstanding+buffered, imem_req_valid drops, Instr_D held; on release, buffered words appear in order with no loss or duplicate.
- Redirect with 2 in flight: PCSrc_E=1, PCTarget_E=32'h100 → both old responses discarded (drop_cnt 2→0); next Instr_D has PC_D=0x100; flash_D gives inst_valid_D=0 the following cycle.
- Redirect coincident with response arrival and one more in flight → arriving word dropped, drop_cnt=1, second dropped, 0x100 fetched next.
- Memory with imem_req_ready=0 for 4 cycles → bubbles (NOP, inst_valid_D=0), pc_q unchanged; then normal flow resumes.
- Async reset asserted mid-stream → all outputs at reset values immediately, without waiting for a clock edge; fetch restarts at RESET_PC.
